// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//    Valid/ready pipeline register carrying an opaque DATA_W-bit payload
//    between two pipeline stages (IF/ID, ID/EX, ...).
//    SKID=0 : one payload register; in_ready_o is combinational from out_ready_i.
//    SKID=1 : two-entry skid buffer (main + skid); in_ready_o is a function
//             of registered state only, so the back-end stall path is cut.
//    A saturating counter tracks cycles where the output is stalled.
//
// Ports
//    clk_i        clock, rising edge
//    rst_ni       asynchronous active-low reset
//    flush_i      synchronous flush, drops held and incoming payloads
//    in_valid_i   upstream payload valid
//    in_ready_o   stage accepts a payload this cycle
//    in_data_i    upstream payload
//    out_valid_o  out_data_o is valid
//    out_ready_i  downstream consumes out_data_o this cycle
//    out_data_o   payload towards the downstream stage
//    occupancy_o  held entries (0..2)
//    stall_cnt_o  saturating count of out_valid_o & ~out_ready_i cycles
module pipe_stage_skid #(
   parameter int unsigned DATA_W         = 107,
   parameter int unsigned SKID           = 1,
   parameter int unsigned CLEAR_ON_FLUSH = 1,
   parameter int unsigned CNT_W          = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occupancy_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   logic             in_ready_s;
   logic             out_valid_s;
   logic             in_fire_s;
   logic             out_fire_s;
   logic [CNT_W-1:0] stall_cnt_r;

   assign in_fire_s  = in_valid_i & in_ready_s;
   assign out_fire_s = out_valid_s & out_ready_i;

   generate
      if (SKID != 0) begin : g_skid
         localparam logic [1:0] ST_EMPTY = 2'd0;
         localparam logic [1:0] ST_ONE   = 2'd1;
         localparam logic [1:0] ST_FULL  = 2'd2;

         logic [1:0]        state_r;
         logic [1:0]        state_nxt_s;
         logic [DATA_W-1:0] main_r;
         logic [DATA_W-1:0] main_nxt_s;
         logic [DATA_W-1:0] skid_r;
         logic [DATA_W-1:0] skid_nxt_s;

         // Next-state and payload steering for the two-entry buffer.
         always_comb begin
            state_nxt_s = state_r;
            main_nxt_s  = main_r;
            skid_nxt_s  = skid_r;
            if (flush_i) begin
               state_nxt_s = ST_EMPTY;
               if (CLEAR_ON_FLUSH != 0) begin
                  main_nxt_s = {DATA_W{1'b0}};
                  skid_nxt_s = {DATA_W{1'b0}};
               end else begin
                  main_nxt_s = main_r;
                  skid_nxt_s = skid_r;
               end
            end else begin
               case (state_r)
                  ST_EMPTY: begin
                     if (in_fire_s) begin
                        state_nxt_s = ST_ONE;
                        main_nxt_s  = in_data_i;
                     end else begin
                        state_nxt_s = ST_EMPTY;
                     end
                  end
                  ST_ONE: begin
                     if (in_fire_s && out_fire_s) begin
                        main_nxt_s = in_data_i;
                     end else if (in_fire_s) begin
                        // Downstream stalled: park the newcomer behind main.
                        state_nxt_s = ST_FULL;
                        skid_nxt_s  = in_data_i;
                     end else if (out_fire_s) begin
                        state_nxt_s = ST_EMPTY;
                     end else begin
                        state_nxt_s = ST_ONE;
                     end
                  end
                  ST_FULL: begin
                     // in_ready is low here, so only the drain side can move.
                     if (out_fire_s) begin
                        state_nxt_s = ST_ONE;
                        main_nxt_s  = skid_r;
                     end else begin
                        state_nxt_s = ST_FULL;
                     end
                  end
                  default: begin
                     state_nxt_s = ST_EMPTY;
                  end
               endcase
            end
         end

         // Buffer state and payload registers.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               state_r <= ST_EMPTY;
               main_r  <= {DATA_W{1'b0}};
               skid_r  <= {DATA_W{1'b0}};
            end else begin
               state_r <= state_nxt_s;
               main_r  <= main_nxt_s;
               skid_r  <= skid_nxt_s;
            end
         end

         assign out_valid_s = (state_r != ST_EMPTY);
         assign in_ready_s  = (state_r != ST_FULL);
         assign out_data_o  = main_r;
         assign occupancy_o = (state_r == ST_FULL) ? 2'd2 :
                              (state_r == ST_ONE)  ? 2'd1 : 2'd0;
      end else begin : g_single
         logic              valid_r;
         logic              valid_nxt_s;
         logic [DATA_W-1:0] main_r;
         logic [DATA_W-1:0] main_nxt_s;

         // Next-state for the single register; a fill wins over a drain.
         always_comb begin
            valid_nxt_s = valid_r;
            main_nxt_s  = main_r;
            if (flush_i) begin
               valid_nxt_s = 1'b0;
               if (CLEAR_ON_FLUSH != 0) begin
                  main_nxt_s = {DATA_W{1'b0}};
               end else begin
                  main_nxt_s = main_r;
               end
            end else if (in_fire_s) begin
               valid_nxt_s = 1'b1;
               main_nxt_s  = in_data_i;
            end else if (out_fire_s) begin
               valid_nxt_s = 1'b0;
            end else begin
               valid_nxt_s = valid_r;
            end
         end

         // Valid flag and payload register.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               valid_r <= 1'b0;
               main_r  <= {DATA_W{1'b0}};
            end else begin
               valid_r <= valid_nxt_s;
               main_r  <= main_nxt_s;
            end
         end

         assign out_valid_s = valid_r;
         assign in_ready_s  = out_ready_i | ~valid_r;
         assign out_data_o  = main_r;
         assign occupancy_o = {1'b0, valid_r};
      end
   endgenerate

   // Saturating stall counter; flush does not touch it, only reset clears it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (out_valid_s && !out_ready_i && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign in_ready_o  = in_ready_s;
   assign out_valid_o = out_valid_s;
   assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid.
//    dut_a : SKID=1, CLEAR_ON_FLUSH=1, CNT_W=16, DATA_W=107
//    dut_c : SKID=1, CNT_W=4, same inputs as dut_a (counter saturation)
//    dut_b : SKID=0, CLEAR_ON_FLUSH=0, DATA_W=8
module tb_pipe_stage_skid;

   logic         clk = 1'b0;
   logic         rst_n;

   logic         a_flush, a_in_valid, a_out_ready;
   logic [106:0] a_data;
   logic         a_in_ready, a_out_valid;
   logic [106:0] a_out_data;
   logic [1:0]   a_occ;
   logic [15:0]  a_cnt;

   logic         c_in_ready, c_out_valid;
   logic [106:0] c_out_data;
   logic [1:0]   c_occ;
   logic [3:0]   c_cnt;

   logic         b_flush, b_in_valid, b_out_ready;
   logic [7:0]   b_data;
   logic         b_in_ready, b_out_valid;
   logic [7:0]   b_out_data;
   logic [1:0]   b_occ;
   logic [15:0]  b_cnt;

   int vectors = 0;
   int miscompares = 0;

   logic [106:0] sb_a[$];
   logic [7:0]   sb_b[$];
   logic [106:0] exp_a;
   logic [7:0]   exp_b;

   pipe_stage_skid #(.DATA_W(107), .SKID(1), .CLEAR_ON_FLUSH(1), .CNT_W(16)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
      .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_data),
      .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
      .occupancy_o(a_occ), .stall_cnt_o(a_cnt));

   pipe_stage_skid #(.DATA_W(107), .SKID(1), .CLEAR_ON_FLUSH(1), .CNT_W(4)) dut_c (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
      .in_valid_i(a_in_valid), .in_ready_o(c_in_ready), .in_data_i(a_data),
      .out_valid_o(c_out_valid), .out_ready_i(a_out_ready), .out_data_o(c_out_data),
      .occupancy_o(c_occ), .stall_cnt_o(c_cnt));

   pipe_stage_skid #(.DATA_W(8), .SKID(0), .CLEAR_ON_FLUSH(0), .CNT_W(16)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
      .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_data),
      .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
      .occupancy_o(b_occ), .stall_cnt_o(b_cnt));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Mid-low-phase sample point; record accepted payloads as expected outputs.
   task automatic sample();
      @(negedge clk);
      if (a_in_valid && a_in_ready && !a_flush) sb_a.push_back(a_data);
      if (b_in_valid && b_in_ready && !b_flush) sb_b.push_back(b_data);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_data = '0;
      b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_data = 8'h00;

      // Monitor: pops expected payload whenever an output transfer happens.
      fork
         forever begin
            @(negedge clk);
            if (rst_n) begin
               if (a_out_valid && a_out_ready) begin
                  if (sb_a.size() == 0) begin
                     vectors++; miscompares++;
                     $display("FAIL a_unexpected_out: got %0h expected none", a_out_data);
                  end else begin
                     exp_a = sb_a.pop_front();
                     chk("a_out_data", a_out_data, exp_a);
                  end
               end
               if (b_out_valid && b_out_ready) begin
                  if (sb_b.size() == 0) begin
                     vectors++; miscompares++;
                     $display("FAIL b_unexpected_out: got %0h expected none", b_out_data);
                  end else begin
                     exp_b = sb_b.pop_front();
                     chk("b_out_data", b_out_data, exp_b);
                  end
               end
            end
         end
      join_none

      // Reset state
      repeat (2) begin sample(); advance(); end
      sample();
      chk("rst_a_valid", a_out_valid, 0);
      chk("rst_a_data", a_out_data, 0);
      chk("rst_a_occ", a_occ, 0);
      chk("rst_a_in_ready", a_in_ready, 1);
      chk("rst_a_cnt", a_cnt, 0);
      chk("rst_c_cnt", c_cnt, 0);
      chk("rst_b_valid", b_out_valid, 0);
      chk("rst_b_in_ready", b_in_ready, 1);
      chk("rst_b_cnt", b_cnt, 0);
      rst_n = 1'b1;
      advance();

      // Streaming 1..8 through both variants
      for (int i = 1; i <= 8; i++) begin
         a_in_valid = 1'b1; a_data = 107'(i); a_out_ready = 1'b1;
         b_in_valid = 1'b1; b_data = 8'(i);   b_out_ready = 1'b1;
         sample();
         if (i > 1) begin
            chk("stream_a_occ", a_occ, 1);
            chk("stream_a_lat", a_out_data, i - 1);
            chk("stream_b_occ", b_occ, 1);
            chk("stream_b_lat", b_out_data, i - 1);
         end
         advance();
      end
      a_in_valid = 1'b0; b_in_valid = 1'b0;
      sample();
      chk("stream_a_occ_last", a_occ, 1);
      advance();
      sample();
      chk("stream_a_drained", a_occ, 0);
      chk("stream_a_cnt", a_cnt, 0);
      chk("stream_b_drained", b_out_valid, 0);
      advance();

      // Backpressure on the skid buffer
      a_out_ready = 1'b0; a_in_valid = 1'b1; a_data = 107'hA;
      sample(); advance();
      a_data = 107'hB;
      sample();
      chk("bp_ready_one", a_in_ready, 1);
      advance();
      a_data = 107'hC;
      sample();
      chk("bp_occ_full", a_occ, 2);
      chk("bp_ready_full", a_in_ready, 0);
      chk("bp_cnt_1", a_cnt, 1);
      advance();
      for (int k = 0; k < 4; k++) begin
         sample();
         chk("bp_hold_ready", a_in_ready, 0);
         chk("bp_hold_data", a_out_data, 107'hA);
         advance();
      end
      a_out_ready = 1'b1;
      sample();
      chk("bp_cnt_6", a_cnt, 6);
      chk("bp_c_cnt_6", c_cnt, 6);
      chk("bp_occ_still_full", a_occ, 2);
      advance();
      sample(); advance();
      a_in_valid = 1'b0;
      sample(); advance();
      sample();
      chk("bp_drained", a_occ, 0);
      chk("bp_cnt_kept", a_cnt, 6);
      advance();

      // Flush while FULL with a simultaneous offer of 0xFF
      a_out_ready = 1'b0; a_in_valid = 1'b1; a_data = 107'h11;
      sample(); advance();
      a_data = 107'h22;
      sample(); advance();
      a_flush = 1'b1; a_data = 107'hFF;
      sample();
      chk("fl_occ_before", a_occ, 2);
      chk("fl_cnt_before", a_cnt, 7);
      advance();
      sb_a.delete();
      a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
      sample();
      chk("fl_valid", a_out_valid, 0);
      chk("fl_data_zero", a_out_data, 0);
      chk("fl_occ", a_occ, 0);
      chk("fl_in_ready", a_in_ready, 1);
      chk("fl_cnt", a_cnt, 8);
      chk("fl_c_cnt", c_cnt, 8);
      advance();
      sample();
      chk("fl_no_ff", a_out_valid, 0);
      advance();

      // SKID=0, CLEAR_ON_FLUSH=0
      b_out_ready = 1'b0; b_in_valid = 1'b1; b_data = 8'h55;
      sample(); advance();
      b_in_valid = 1'b0;
      sample();
      chk("s0_valid", b_out_valid, 1);
      chk("s0_data", b_out_data, 8'h55);
      chk("s0_ready_low", b_in_ready, 0);
      chk("s0_occ", b_occ, 1);
      #1 b_out_ready = 1'b1;
      #1 chk("s0_ready_comb_hi", b_in_ready, 1);
      b_out_ready = 1'b0;
      #1 chk("s0_ready_comb_lo", b_in_ready, 0);
      advance();
      b_flush = 1'b1;
      sample(); advance();
      sb_b.delete();
      b_flush = 1'b0;
      sample();
      chk("s0_fl_valid", b_out_valid, 0);
      chk("s0_fl_data_held", b_out_data, 8'h55);
      chk("s0_fl_occ", b_occ, 0);
      chk("s0_fl_ready", b_in_ready, 1);
      advance();

      // Counter saturation on the 4-bit instance
      a_out_ready = 1'b0; a_in_valid = 1'b1; a_data = 107'h33;
      sample(); advance();
      a_in_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         sample();
         if (k == 8) chk("sat_c_reach", c_cnt, 15);
         chk("sat_a_stable", a_out_data, 107'h33);
         advance();
      end
      sample();
      chk("sat_c_stay", c_cnt, 15);
      chk("sat_a_cnt", a_cnt, 28);
      chk("sat_c_occ", c_occ, 1);
      chk("sat_c_data", c_out_data, 107'h33);
      chk("sat_c_valid", c_out_valid, 1);
      chk("sat_c_ready", c_in_ready, 1);
      advance();
      a_out_ready = 1'b1;
      sample(); advance();
      sample();
      chk("sat_drained", a_occ, 0);
      advance();

      // Asynchronous reset mid-stream while FULL
      a_out_ready = 1'b0; a_in_valid = 1'b1; a_data = 107'h44;
      sample(); advance();
      a_data = 107'h66;
      sample(); advance();
      a_in_valid = 1'b0;
      sample();
      chk("ar_occ_full", a_occ, 2);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_valid", a_out_valid, 0);
      chk("ar_data", a_out_data, 0);
      chk("ar_occ", a_occ, 0);
      chk("ar_in_ready", a_in_ready, 1);
      chk("ar_cnt", a_cnt, 0);
      chk("ar_c_cnt", c_cnt, 0);
      #1 rst_n = 1'b1;
      sb_a.delete(); sb_b.delete();
      advance();

      // Recovery after reset
      a_in_valid = 1'b1; a_data = 107'h77; a_out_ready = 1'b1;
      sample(); advance();
      a_in_valid = 1'b0;
      sample(); advance();
      sample();
      chk("end_sb_a_empty", sb_a.size(), 0);
      chk("end_sb_b_empty", sb_b.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
